// File: rtl/jtkcpu_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : jtkcpu_bus_master
// Purpose  : Bus initiator for the jtkcpu memory bus (CPU side). Accepts
//            single or burst commands on a valid/ready port, runs them on the
//            cen2-paced addr/dout/we bus with dtack wait states and a per-beat
//            timeout, and returns one response pulse per beat. Burst writes are
//            block fills: the same byte goes to consecutive addresses.
// Ports    : clk, rst (sync, active-high), cen2 (bus clock enable)
//            cmd_valid/cmd_ready, cmd_we, cmd_addr, cmd_wdata, cmd_len
//            rsp_valid, rsp_rdata, rsp_last, rsp_err
//            addr, dout, we (bus outputs), din, dtack (bus inputs)
// Revision : 1.0 - initial release
// ============================================================================
module jtkcpu_bus_master #(
  parameter int TIMEOUT = 15,
  parameter int AW      = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen2,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_addr,
  input  logic [7:0]    cmd_wdata,
  input  logic [3:0]    cmd_len,
  output logic          rsp_valid,
  output logic [7:0]    rsp_rdata,
  output logic          rsp_last,
  output logic          rsp_err,
  output logic [AW-1:0] addr,
  output logic [7:0]    dout,
  output logic          we,
  input  logic [7:0]    din,
  input  logic          dtack
);

  localparam logic [7:0] c_timeout = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_SAMPLE = 2'd2
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_wait_cnt;
  logic [3:0] r_remain;
  logic       w_accept;
  logic       w_beat_done;
  logic       w_beat_abort;
  logic       w_wait;
  logic       w_setup_strobe;

  // Next-state and control decode
  always_comb begin
    w_state_nxt    = r_state;
    w_accept       = 1'b0;
    w_beat_done    = 1'b0;
    w_beat_abort   = 1'b0;
    w_wait         = 1'b0;
    w_setup_strobe = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Accept is independent of cen2; the bus phase starts in SETUP.
        if (cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        // One full cen2 period of stable address before the first sample.
        if (cen2) begin
          w_setup_strobe = 1'b1;
          w_state_nxt    = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (cen2) begin
          if (dtack) begin
            w_beat_done = 1'b1;
            w_state_nxt = (r_remain == 4'd0) ? S_IDLE : S_SETUP;
          end else if (r_wait_cnt == c_timeout) begin
            w_beat_abort = 1'b1;
            w_state_nxt  = S_IDLE;
          end else begin
            w_wait = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign cmd_ready = (r_state == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Bus and response datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= 8'd0;
      r_remain   <= 4'd0;
      addr       <= '0;
      dout       <= 8'd0;
      we         <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 8'd0;
      rsp_last   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'd0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;

      if (w_accept) begin
        addr     <= cmd_addr;
        dout     <= cmd_wdata;
        we       <= cmd_we;
        r_remain <= cmd_len;
      end

      if (w_setup_strobe) begin
        r_wait_cnt <= 8'd0;
      end

      if (w_wait) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end

      if (w_beat_done) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= we ? 8'd0 : din;
        rsp_last  <= (r_remain == 4'd0);
        if (r_remain == 4'd0) begin
          // Last beat: release the write strobe; addr/dout keep last values.
          we <= 1'b0;
        end else begin
          addr     <= addr + AW'(1);
          r_remain <= r_remain - 4'd1;
        end
      end

      if (w_beat_abort) begin
        rsp_valid <= 1'b1;
        rsp_last  <= 1'b1;
        rsp_err   <= 1'b1;
        we        <= 1'b0;
        r_remain  <= 4'd0;
      end
    end
  end

endmodule
`default_nettype wire
